// File: rtl/axil_led_pkg.sv
// Shared definitions for the AXI4-Lite LED controller: register offsets,
// response codes, channel modes and the channel configuration record.
package axil_led_pkg;

  localparam logic [31:0] VERSION_DEFAULT = 32'h0001_0000;

  localparam int unsigned OFS_CTRL     = 'h00;
  localparam int unsigned OFS_ID       = 'h04;
  localparam int unsigned OFS_PRESCALE = 'h08;
  localparam int unsigned OFS_CH_BASE  = 'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } led_mode_e;

  typedef struct packed {
    logic [7:0] half;
    logic [7:0] duty;
    led_mode_e  mode;
  } chan_cfg_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] cfg_to_word(input chan_cfg_t c);
    return {8'h00, c.half, c.duty, 6'b0, c.mode};
  endfunction

  function automatic chan_cfg_t word_to_cfg(input logic [31:0] w);
    chan_cfg_t c;
    c.half = w[23:16];
    c.duty = w[15:8];
    c.mode = led_mode_e'(w[1:0]);
    return c;
  endfunction

endpackage

// File: rtl/axil_led_chan.sv
// One LED channel: per-channel blink counter plus a registered LED output
// selected by the channel mode (off / on / blink / shared-counter PWM).
module axil_led_chan
  import axil_led_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       en,
  input  logic [7:0] pwm_cnt,
  input  chan_cfg_t  cfg,
  input  logic       cfg_wr,
  output logic       led
);

  logic [7:0] blk_cnt_q, blk_cnt_d;
  logic       blk_q, blk_d;
  logic       led_q, led_d;
  logic       mode_on;

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    blk_d     = blk_q;
    // A config write restarts the blink phase so the new setting starts clean.
    if (cfg_wr) begin
      blk_cnt_d = '0;
      blk_d     = 1'b0;
    end else if (tick) begin
      if (blk_cnt_q >= cfg.half) begin
        blk_cnt_d = '0;
        blk_d     = ~blk_q;
      end else begin
        blk_cnt_d = blk_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    mode_on = 1'b0;
    unique case (cfg.mode)
      MODE_OFF:   mode_on = 1'b0;
      MODE_ON:    mode_on = 1'b1;
      MODE_BLINK: mode_on = blk_q;
      MODE_PWM:   mode_on = (pwm_cnt < cfg.duty);
      default:    mode_on = 1'b0;
    endcase
    led_d = en & mode_on;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt_q <= '0;
      blk_q     <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      blk_q     <= blk_d;
      led_q     <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/axil_led_ctrl.sv
// AXI4-Lite slave driving NUM_LED board LEDs with per-channel off/on/blink/PWM
// modes, all timed from a shared software-programmable tick prescaler.
module axil_led_ctrl
  import axil_led_pkg::*;
#(
  parameter int unsigned NUM_LED = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned PRE_W   = 16,
  parameter logic [31:0] VERSION = VERSION_DEFAULT
) (
  input  logic              axi_clk_in,
  input  logic              axi_rst_n_in,
  input  logic [ADDR_W-1:0] S_AXI_awaddr,
  input  logic              S_AXI_awvalid,
  output logic              S_AXI_awready,
  input  logic [31:0]       S_AXI_wdata,
  input  logic [3:0]        S_AXI_wstrb,
  input  logic              S_AXI_wvalid,
  output logic              S_AXI_wready,
  output logic [1:0]        S_AXI_bresp,
  output logic              S_AXI_bvalid,
  input  logic              S_AXI_bready,
  input  logic [ADDR_W-1:0] S_AXI_araddr,
  input  logic              S_AXI_arvalid,
  output logic              S_AXI_arready,
  output logic [31:0]       S_AXI_rdata,
  output logic [1:0]        S_AXI_rresp,
  output logic              S_AXI_rvalid,
  input  logic              S_AXI_rready,
  output logic [NUM_LED-1:0] led_out
);

  logic              out_en_q;
  logic              aw_full_q, aw_full_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_full_q, w_full_d;
  logic [31:0]       w_data_q, w_data_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              ctrl_en_q, ctrl_en_d;
  logic [PRE_W-1:0]  prescale_q, prescale_d;
  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [7:0]        pwm_cnt_q, pwm_cnt_d;
  chan_cfg_t         ch_cfg_q [NUM_LED];
  chan_cfg_t         ch_cfg_d [NUM_LED];
  logic [NUM_LED-1:0] ch_wr;

  logic              aw_hs, w_hs, ar_hs, wr_fire, tick;
  logic              wr_hit, rd_hit;
  logic [31:0]       wr_cur, wr_new, rd_val;
  logic [ADDR_W-1:0] wr_a;

  // Returns {hit, data}; data is zero for unmapped addresses.
  function automatic logic [32:0] reg_read(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] a;
    logic [32:0]       r;
    a = {addr[ADDR_W-1:2], 2'b00};
    r = '0;
    if (a == ADDR_W'(OFS_CTRL))          r = {1'b1, 31'b0, ctrl_en_q};
    else if (a == ADDR_W'(OFS_ID))       r = {1'b1, VERSION};
    else if (a == ADDR_W'(OFS_PRESCALE)) r = {1'b1, 32'(prescale_q)};
    else begin
      for (int unsigned i = 0; i < NUM_LED; i++) begin
        if (a == ADDR_W'(OFS_CH_BASE + 4*i)) r = {1'b1, cfg_to_word(ch_cfg_q[i])};
      end
    end
    return r;
  endfunction

  assign S_AXI_awready = out_en_q & ~aw_full_q & ~bvalid_q;
  assign S_AXI_wready  = out_en_q & ~w_full_q & ~bvalid_q;
  assign S_AXI_arready = out_en_q & ~rvalid_q;
  assign S_AXI_bvalid  = bvalid_q;
  assign S_AXI_bresp   = bresp_q;
  assign S_AXI_rvalid  = rvalid_q;
  assign S_AXI_rdata   = rdata_q;
  assign S_AXI_rresp   = rresp_q;

  assign aw_hs   = S_AXI_awvalid & S_AXI_awready;
  assign w_hs    = S_AXI_wvalid & S_AXI_wready;
  assign ar_hs   = S_AXI_arvalid & S_AXI_arready;
  assign wr_fire = aw_full_q & w_full_q;
  assign wr_a    = {aw_addr_q[ADDR_W-1:2], 2'b00};

  // Write commits merge the strobed bytes into the current register image.
  always_comb begin
    aw_full_d  = aw_full_q;
    aw_addr_d  = aw_addr_q;
    w_full_d   = w_full_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    ctrl_en_d  = ctrl_en_q;
    prescale_d = prescale_q;
    ch_cfg_d   = ch_cfg_q;
    ch_wr      = '0;
    {wr_hit, wr_cur} = reg_read(aw_addr_q);
    wr_new = strb_merge(wr_cur, w_data_q, w_strb_q);

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = S_AXI_awaddr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = S_AXI_wdata;
      w_strb_d = S_AXI_wstrb;
    end
    if (bvalid_q && S_AXI_bready) bvalid_d = 1'b0;

    if (wr_fire) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_hit ? RESP_OKAY : RESP_SLVERR;
      if (wr_a == ADDR_W'(OFS_CTRL))     ctrl_en_d  = wr_new[0];
      if (wr_a == ADDR_W'(OFS_PRESCALE)) prescale_d = wr_new[PRE_W-1:0];
      for (int unsigned i = 0; i < NUM_LED; i++) begin
        if (wr_a == ADDR_W'(OFS_CH_BASE + 4*i)) begin
          ch_cfg_d[i] = word_to_cfg(wr_new);
          ch_wr[i]    = 1'b1;
        end
      end
    end
  end

  // Read mux samples pre-write state, so a coincident write is not visible.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    {rd_hit, rd_val} = reg_read(S_AXI_araddr);
    if (rvalid_q && S_AXI_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      rresp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign tick = (pre_cnt_q == prescale_q);

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'(tick);
    if (pre_cnt_q >= prescale_q) pre_cnt_d = '0;
    else                         pre_cnt_d = pre_cnt_q + PRE_W'(1);
  end

  always_ff @(posedge axi_clk_in or negedge axi_rst_n_in) begin
    if (!axi_rst_n_in) begin
      out_en_q   <= 1'b0;
      aw_full_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      ctrl_en_q  <= 1'b0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      for (int unsigned i = 0; i < NUM_LED; i++) ch_cfg_q[i] <= '0;
    end else begin
      out_en_q   <= 1'b1;
      aw_full_q  <= aw_full_d;
      aw_addr_q  <= aw_addr_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      ctrl_en_q  <= ctrl_en_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      ch_cfg_q   <= ch_cfg_d;
    end
  end

  for (genvar i = 0; i < NUM_LED; i++) begin : g_chan
    axil_led_chan u_chan (
      .clk     (axi_clk_in),
      .rst_n   (axi_rst_n_in),
      .tick    (tick),
      .en      (ctrl_en_q),
      .pwm_cnt (pwm_cnt_q),
      .cfg     (ch_cfg_q[i]),
      .cfg_wr  (ch_wr[i]),
      .led     (led_out[i])
    );
  end

endmodule

// File: tb/tb_axil_led_ctrl.sv
// Self-checking bench for axil_led_ctrl: bus responses are scoreboarded,
// LED timing is measured directly on led_out.
module tb_axil_led_ctrl;

  localparam int unsigned NUM_LED = 4;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned PRE_W   = 16;
  localparam logic [31:0] VER     = 32'h0001_0000;
  localparam logic [1:0]  OK      = 2'b00;
  localparam logic [1:0]  SLV     = 2'b10;

  logic              clk, rst_n;
  logic [ADDR_W-1:0] S_AXI_awaddr, S_AXI_araddr;
  logic              S_AXI_awvalid, S_AXI_awready;
  logic [31:0]       S_AXI_wdata, S_AXI_rdata;
  logic [3:0]        S_AXI_wstrb;
  logic              S_AXI_wvalid, S_AXI_wready;
  logic [1:0]        S_AXI_bresp, S_AXI_rresp;
  logic              S_AXI_bvalid, S_AXI_bready;
  logic              S_AXI_arvalid, S_AXI_arready;
  logic              S_AXI_rvalid, S_AXI_rready;
  logic [NUM_LED-1:0] led_out;

  axil_led_ctrl #(
    .NUM_LED (NUM_LED),
    .ADDR_W  (ADDR_W),
    .PRE_W   (PRE_W),
    .VERSION (VER)
  ) dut (
    .axi_clk_in    (clk),
    .axi_rst_n_in  (rst_n),
    .S_AXI_awaddr  (S_AXI_awaddr),
    .S_AXI_awvalid (S_AXI_awvalid),
    .S_AXI_awready (S_AXI_awready),
    .S_AXI_wdata   (S_AXI_wdata),
    .S_AXI_wstrb   (S_AXI_wstrb),
    .S_AXI_wvalid  (S_AXI_wvalid),
    .S_AXI_wready  (S_AXI_wready),
    .S_AXI_bresp   (S_AXI_bresp),
    .S_AXI_bvalid  (S_AXI_bvalid),
    .S_AXI_bready  (S_AXI_bready),
    .S_AXI_araddr  (S_AXI_araddr),
    .S_AXI_arvalid (S_AXI_arvalid),
    .S_AXI_arready (S_AXI_arready),
    .S_AXI_rdata   (S_AXI_rdata),
    .S_AXI_rresp   (S_AXI_rresp),
    .S_AXI_rvalid  (S_AXI_rvalid),
    .S_AXI_rready  (S_AXI_rready),
    .led_out       (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  string       exp_tag_q[$];
  logic [31:0] exp_rd_q[$];
  logic [1:0]  exp_rresp_q[$];
  logic [1:0]  exp_bresp_q[$];
  time         last_b_time;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    string tag;
    if (rst_n) begin
      if (S_AXI_rvalid) begin
        if (exp_rd_q.size() == 0) check("r_unexpected", 32'd1, 32'd0);
        else begin
          tag = exp_tag_q.pop_front();
          check({tag, "_rdata"}, S_AXI_rdata, exp_rd_q.pop_front());
          check({tag, "_rresp"}, 32'(S_AXI_rresp), 32'(exp_rresp_q.pop_front()));
        end
      end
      if (S_AXI_bvalid) begin
        last_b_time = $time;
        if (exp_bresp_q.size() == 0) check("b_unexpected", 32'd1, 32'd0);
        else check("bresp", 32'(S_AXI_bresp), 32'(exp_bresp_q.pop_front()));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp, input int aw_delay);
    bit aw_done, w_done, aw_hs, w_hs;
    cycles(1);
    exp_bresp_q.push_back(resp);
    S_AXI_wdata  = data;
    S_AXI_wstrb  = strb;
    S_AXI_wvalid = 1'b1;
    aw_done = 0;
    w_done  = 0;
    for (int cyc = 0; cyc < 40 && !(aw_done && w_done); cyc++) begin
      if (cyc == aw_delay) begin
        S_AXI_awaddr  = addr;
        S_AXI_awvalid = 1'b1;
      end
      aw_hs = S_AXI_awvalid && S_AXI_awready;
      w_hs  = S_AXI_wvalid && S_AXI_wready;
      cycles(1);
      if (aw_hs) begin S_AXI_awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin S_AXI_wvalid  = 1'b0; w_done  = 1; end
    end
    S_AXI_awvalid = 1'b0;
    S_AXI_wvalid  = 1'b0;
    if (!(aw_done && w_done)) check("wr_handshake_timeout", 32'd0, 32'd1);
    for (int c = 0; c < 20 && exp_bresp_q.size() != 0; c++) cycles(1);
    if (exp_bresp_q.size() != 0) begin
      check("b_timeout", 32'd0, 32'd1);
      exp_bresp_q.delete();
    end
  endtask

  task automatic axi_read(input string tag, input logic [7:0] addr,
                          input logic [31:0] data, input logic [1:0] resp);
    bit done, hs;
    cycles(1);
    exp_tag_q.push_back(tag);
    exp_rd_q.push_back(data);
    exp_rresp_q.push_back(resp);
    S_AXI_araddr  = addr;
    S_AXI_arvalid = 1'b1;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      hs = S_AXI_arvalid && S_AXI_arready;
      cycles(1);
      if (hs) begin S_AXI_arvalid = 1'b0; done = 1; end
    end
    S_AXI_arvalid = 1'b0;
    if (!done) check({tag, "_ar_timeout"}, 32'd0, 32'd1);
    for (int c = 0; c < 20 && exp_rd_q.size() != 0; c++) cycles(1);
    if (exp_rd_q.size() != 0) begin
      check({tag, "_r_timeout"}, 32'd0, 32'd1);
      exp_tag_q.delete();
      exp_rd_q.delete();
      exp_rresp_q.delete();
    end
  endtask

  task automatic count_high(input int idx, input int n, output int cnt);
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (led_out[idx]) cnt++;
    end
    cycles(1);
  endtask

  task automatic wait_led_change(input int idx, output time t);
    logic prev;
    bit   seen;
    prev = led_out[idx];
    seen = 0;
    t    = $time;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (led_out[idx] !== prev) begin seen = 1; t = $time; end
    end
    if (!seen) check("led_change_timeout", 32'd0, 32'd1);
    cycles(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  cnt;
    time t0, t1, t2, t3;
    rst_n = 1'b0;
    S_AXI_awaddr = '0; S_AXI_awvalid = 1'b0;
    S_AXI_wdata = '0; S_AXI_wstrb = '0; S_AXI_wvalid = 1'b0;
    S_AXI_araddr = '0; S_AXI_arvalid = 1'b0;
    S_AXI_bready = 1'b1; S_AXI_rready = 1'b1;
    cycles(3);
    check("rst_handshake", 32'({S_AXI_awready, S_AXI_wready, S_AXI_arready, S_AXI_bvalid,
                                S_AXI_rvalid, S_AXI_bresp, S_AXI_rresp}), 32'd0);
    check("rst_rdata", S_AXI_rdata, 32'd0);
    check("rst_led", 32'(led_out), 32'd0);
    rst_n = 1'b1;
    cycles(2);

    axi_read("init_ctrl", 8'h00, 32'd0, OK);
    axi_read("init_prescale", 8'h08, 32'd0, OK);
    axi_read("init_ch3", 8'h1C, 32'd0, OK);
    axi_read("init_id", 8'h04, VER, OK);

    // Reset arriving after AW is accepted but before W.
    axi_write(8'h00, 32'h1, 4'hF, OK, 0);
    axi_write(8'h10, 32'h1, 4'hF, OK, 0);
    cycles(2);
    check("led_on_ch0", 32'(led_out), 32'h1);
    S_AXI_awaddr  = 8'h00;
    S_AXI_awvalid = 1'b1;
    cycles(1);
    S_AXI_awvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_led", 32'(led_out), 32'd0);
    check("midrst_bvalid", 32'(S_AXI_bvalid), 32'd0);
    check("midrst_ready", 32'({S_AXI_awready, S_AXI_wready, S_AXI_arready}), 32'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    axi_read("midrst_ctrl", 8'h00, 32'd0, OK);
    axi_read("midrst_ch0", 8'h10, 32'd0, OK);

    axi_write(8'h00, 32'h1, 4'hF, OK, 3);
    cycles(3);
    axi_read("split_ctrl", 8'h00, 32'h1, OK);

    axi_write(8'h10, 32'h00FF_FF03, 4'hF, OK, 0);
    axi_read("strb_full", 8'h10, 32'h00FF_FF03, OK);
    axi_write(8'h10, 32'h0, 4'b0010, OK, 0);
    axi_read("strb_byte1", 8'h10, 32'h00FF_0003, OK);
    axi_write(8'h10, 32'h0, 4'b0100, OK, 0);
    axi_read("strb_byte2", 8'h10, 32'h0000_0003, OK);

    axi_write(8'h08, 32'h0001_1234, 4'hF, OK, 0);
    axi_read("prescale_unaligned", 8'h0A, 32'h0000_1234, OK);

    axi_write(8'h08, 32'h0, 4'hF, OK, 0);
    axi_write(8'h14, 32'h0000_4003, 4'hF, OK, 0);
    cycles(3);
    count_high(1, 256, cnt);
    check("pwm64_win0", 32'(cnt), 32'd64);
    count_high(1, 256, cnt);
    check("pwm64_win1", 32'(cnt), 32'd64);
    axi_write(8'h14, 32'h0000_FF03, 4'hF, OK, 0);
    cycles(3);
    count_high(1, 256, cnt);
    check("pwm255", 32'(cnt), 32'd255);
    axi_write(8'h14, 32'h0000_0003, 4'hF, OK, 0);
    cycles(3);
    count_high(1, 256, cnt);
    check("pwm0", 32'(cnt), 32'd0);
    axi_write(8'h14, 32'h0, 4'hF, OK, 0);

    axi_write(8'h08, 32'd9, 4'hF, OK, 0);
    axi_write(8'h18, 32'h0004_0002, 4'hF, OK, 0);
    wait_led_change(2, t1);
    wait_led_change(2, t2);
    wait_led_change(2, t3);
    check("blink_period_a", 32'(t2 - t1), 32'd500);
    check("blink_period_b", 32'(t3 - t2), 32'd500);
    if (led_out[2] !== 1'b1) wait_led_change(2, t3);
    cycles(20);
    axi_write(8'h18, 32'h0004_0002, 4'hF, OK, 0);
    cycles(1);
    check("blink_rewrite_clears", 32'(led_out[2]), 32'd0);
    wait_led_change(2, t0);
    check("blink_restart_phase",
          32'((t0 - last_b_time) >= 420 && (t0 - last_b_time) <= 510), 32'd1);
    check("blink_restart_level", 32'(led_out[2]), 32'd1);

    axi_read("err_rd_fc", 8'hFC, 32'd0, SLV);
    axi_read("err_rd_20", 8'h20, 32'd0, SLV);
    axi_write(8'h0C, 32'hFFFF_FFFF, 4'hF, SLV, 0);
    axi_write(8'h04, 32'h0000_DEAD, 4'hF, OK, 0);
    axi_read("err_id", 8'h04, VER, OK);
    axi_read("err_ctrl", 8'h00, 32'h1, OK);
    axi_read("err_prescale", 8'h08, 32'd9, OK);
    axi_read("err_ch0", 8'h10, 32'h0000_0003, OK);
    axi_read("err_ch1", 8'h14, 32'd0, OK);
    axi_read("err_ch2", 8'h18, 32'h0004_0002, OK);
    axi_read("err_ch3", 8'h1C, 32'd0, OK);
    cycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
